cpu_bus_arbiter: RTL

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

---
 rtl/cpu_bus_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_arbiter
// Brief    : Fetch/data to single-bus arbiter with bounded fetch starvation.
//            Optional ARBITER_PERF_EN adds grant and wait-cycle counters.
// Revision : 1.0
// ============================================================================
module cpu_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_request,
  input  logic [31:0] i_fetch_address,
  output logic [31:0] o_fetch_rdata,
  output logic        o_fetch_ready,
  input  logic        i_data_request,
  input  logic        i_data_rw,
  input  logic [31:0] i_data_address,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_wmask,
  output logic [31:0] o_data_rdata,
  output logic        o_data_ready,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wmask,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata
`ifdef ARBITER_PERF_EN
  ,
  output logic [31:0] o_perf_fetch_grants,
  output logic [31:0] o_perf_data_grants,
  output logic [31:0] o_perf_wait_cycles
`endif
);

  localparam int c_CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DATA    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  logic [c_CNT_W-1:0] r_starve, w_starve_next;
  logic        r_bus_request, w_bus_request;
  logic        r_bus_rw,      w_bus_rw;
  logic [31:0] r_bus_address, w_bus_address;
  logic [31:0] r_bus_wdata,   w_bus_wdata;
  logic [3:0]  r_bus_wmask,   w_bus_wmask;
  logic [31:0] r_fetch_rdata, w_fetch_rdata;
  logic        r_fetch_ready, w_fetch_ready;
  logic [31:0] r_data_rdata,  w_data_rdata;
  logic        r_data_ready,  w_data_ready;
  logic        w_fetch_wins;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_starve      <= '0;
      r_bus_request <= 1'b0;
      r_bus_rw      <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata   <= '0;
      r_bus_wmask   <= '0;
      r_fetch_rdata <= '0;
      r_fetch_ready <= 1'b0;
      r_data_rdata  <= '0;
      r_data_ready  <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_starve      <= w_starve_next;
      r_bus_request <= w_bus_request;
      r_bus_rw      <= w_bus_rw;
      r_bus_address <= w_bus_address;
      r_bus_wdata   <= w_bus_wdata;
      r_bus_wmask   <= w_bus_wmask;
      r_fetch_rdata <= w_fetch_rdata;
      r_fetch_ready <= w_fetch_ready;
      r_data_rdata  <= w_data_rdata;
      r_data_ready  <= w_data_ready;
    end
  end

  // Data normally wins; fetch wins once it has been passed over STARVE_LIMIT times.
  assign w_fetch_wins = i_fetch_request &&
                        (!i_data_request || (r_starve == c_STARVE_MAX));

  always_comb begin
    w_state_next  = r_state;
    w_starve_next = r_starve;
    w_bus_request = r_bus_request;
    w_bus_rw      = r_bus_rw;
    w_bus_address = r_bus_address;
    w_bus_wdata   = r_bus_wdata;
    w_bus_wmask   = r_bus_wmask;
    w_fetch_rdata = r_fetch_rdata;
    w_fetch_ready = 1'b0;
    w_data_rdata  = r_data_rdata;
    w_data_ready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fetch_wins) begin
          w_state_next  = S_FETCH;
          w_starve_next = '0;
          w_bus_request = 1'b1;
          w_bus_rw      = 1'b0;
          w_bus_address = i_fetch_address;
          w_bus_wdata   = '0;
          w_bus_wmask   = 4'h0;
        end else if (i_data_request) begin
          w_state_next  = S_DATA;
          w_bus_request = 1'b1;
          w_bus_rw      = i_data_rw;
          w_bus_address = i_data_address;
          w_bus_wdata   = i_data_wdata;
          w_bus_wmask   = i_data_wmask;
          if (!i_fetch_request)
            w_starve_next = '0;
          else if (r_starve != c_STARVE_MAX)
            w_starve_next = r_starve + c_CNT_W'(1);
        end
      end
      S_FETCH: begin
        if (i_bus_ready) begin
          w_state_next  = S_RELEASE;
          w_bus_request = 1'b0;
          w_fetch_rdata = i_bus_rdata;
          w_fetch_ready = 1'b1;
        end
      end
      S_DATA: begin
        if (i_bus_ready) begin
          w_state_next  = S_RELEASE;
          w_bus_request = 1'b0;
          w_data_rdata  = i_bus_rdata;
          w_data_ready  = 1'b1;
        end
      end
      S_RELEASE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_bus_request = r_bus_request;
  assign o_bus_rw      = r_bus_rw;
  assign o_bus_address = r_bus_address;
  assign o_bus_wdata   = r_bus_wdata;
  assign o_bus_wmask   = r_bus_wmask;
  assign o_fetch_rdata = r_fetch_rdata;
  assign o_fetch_ready = r_fetch_ready;
  assign o_data_rdata  = r_data_rdata;
  assign o_data_ready  = r_data_ready;

`ifdef ARBITER_PERF_EN
  logic [31:0] r_perf_fetch_grants;
  logic [31:0] r_perf_data_grants;
  logic [31:0] r_perf_wait_cycles;
  logic        w_fetch_grant, w_data_grant, w_fetch_wait, w_data_wait;

  assign w_fetch_grant = (r_state == S_IDLE) && (w_state_next == S_FETCH);
  assign w_data_grant  = (r_state == S_IDLE) && (w_state_next == S_DATA);
  // A port waits when it requests but neither holds the bus nor is being answered.
  assign w_fetch_wait  = i_fetch_request && !w_fetch_grant &&
                         (r_state != S_FETCH) && !r_fetch_ready;
  assign w_data_wait   = i_data_request && !w_data_grant &&
                         (r_state != S_DATA) && !r_data_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_perf_fetch_grants <= '0;
      r_perf_data_grants  <= '0;
      r_perf_wait_cycles  <= '0;
    end else begin
      if (w_fetch_grant)
        r_perf_fetch_grants <= r_perf_fetch_grants + 32'd1;
      if (w_data_grant)
        r_perf_data_grants <= r_perf_data_grants + 32'd1;
      if (w_fetch_wait || w_data_wait)
        r_perf_wait_cycles <= r_perf_wait_cycles + 32'd1;
    end
  end

  assign o_perf_fetch_grants = r_perf_fetch_grants;
  assign o_perf_data_grants  = r_perf_data_grants;
  assign o_perf_wait_cycles  = r_perf_wait_cycles;
`endif

endmodule
`default_nettype wire
